ex_wb_stage: RTL and testbench

Pipeline stage directly downstream of the EX shift/ALU unit. It captures each result and carry-out, buffers up to two results in a skid buffer under a valid/ready handshake, and presents them in order to register writeback. It owns the architectural carry flag, which it updates when a result commits. It also answers a register-bypass query from decode.

---
 rtl/ex_wb_stage.sv | 126 ++++++++++++
 tb/tb_ex_wb_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: two-entry skid buffer between EX and writeback.
// Owns the committed carry flag and answers decode bypass queries.
module ex_wb_stage #(
    parameter int unsigned WIDTH              = 32,
    parameter int unsigned RADDR              = 5,
    parameter int unsigned ZERO_REG_HARDWIRED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             ex_cf,
    input  logic             ex_cf_we,
    input  logic [RADDR-1:0] ex_rd,
    input  logic             ex_rd_we,
    input  logic             flush,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_result,
    output logic [RADDR-1:0] wb_rd,
    output logic             wb_rd_we,
    output logic             cf_flag,
    input  logic [RADDR-1:0] fwd_query_rd,
    output logic             fwd_hit,
    output logic [WIDTH-1:0] fwd_data
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] result;
        logic             cf;
        logic             cf_we;
        logic [RADDR-1:0] rd;
        logic             rd_we;
    } entry_t;

    entry_t h, t;
    entry_t h_n, t_n;
    entry_t ent_in;
    logic   ex_ready_n;
    logic   cf_n;
    logic   push, pop;
    logic   zero_dst;
    logic   h_match, t_match;

    assign push = ex_valid & ex_ready;
    assign pop  = h.valid & wb_ready;

    assign zero_dst = (ZERO_REG_HARDWIRED != 0) && (ex_rd == '0);

    // Pack the incoming EX result into an entry, masking writes to x0.
    always_comb begin
        ent_in        = '0;
        ent_in.valid  = 1'b1;
        ent_in.result = ex_result;
        ent_in.cf     = ex_cf;
        ent_in.cf_we  = ex_cf_we;
        ent_in.rd     = ex_rd;
        ent_in.rd_we  = ex_rd_we & ~zero_dst;
    end

    // Next occupancy, ready and committed carry.
    always_comb begin
        h_n  = h;
        t_n  = t;
        cf_n = cf_flag;
        if (flush) begin
            h_n.valid = 1'b0;
            t_n.valid = 1'b0;
        end else begin
            unique case (1'b1)
                (!h.valid): begin
                    if (push) h_n = ent_in;
                end
                (h.valid && !t.valid): begin
                    if (push && pop) h_n = ent_in;
                    else if (pop) h_n.valid = 1'b0;
                    else if (push) t_n = ent_in;
                end
                default: begin
                    if (pop) begin
                        h_n = t;
                        t_n = '0;
                    end
                end
            endcase
            if (pop && h.cf_we) cf_n = h.cf;
        end
        ex_ready_n = ~(h_n.valid & t_n.valid);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            h        <= '0;
            t        <= '0;
            ex_ready <= 1'b1;
            cf_flag  <= 1'b0;
        end else begin
            h        <= h_n;
            t        <= t_n;
            ex_ready <= ex_ready_n;
            cf_flag  <= cf_n;
        end
    end

    // Head entry drives writeback; data reads zero while empty.
    always_comb begin
        wb_valid  = h.valid;
        wb_rd_we  = h.valid & h.rd_we;
        wb_result = h.valid ? h.result : '0;
        wb_rd     = h.valid ? h.rd : '0;
    end

    // Bypass lookup: the newest matching entry wins.
    always_comb begin
        h_match  = h.valid & h.rd_we & (h.rd == fwd_query_rd);
        t_match  = t.valid & t.rd_we & (t.rd == fwd_query_rd);
        fwd_hit  = h_match | t_match;
        fwd_data = '0;
        if (t_match) fwd_data = t.result;
        else if (h_match) fwd_data = h.result;
    end

endmodule

// File: tb/tb_ex_wb_stage.sv
// tb_ex_wb_stage: scenario tasks with a queue scoreboard for
// ex_wb_stage writeback order, carry commits and bypassing.
module tb_ex_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic        ex_cf;
    logic        ex_cf_we;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd;
    logic        wb_rd_we;
    logic        cf_flag;
    logic [4:0]  fwd_query_rd;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rd_we;
        logic        cf;
        logic        cf_we;
    } sb_t;

    sb_t  q[$];
    logic exp_cf;
    int   errors = 0;
    int   checks = 0;

    ex_wb_stage #(
        .WIDTH(32),
        .RADDR(5),
        .ZERO_REG_HARDWIRED(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ex_valid(ex_valid),
        .ex_ready(ex_ready),
        .ex_result(ex_result),
        .ex_cf(ex_cf),
        .ex_cf_we(ex_cf_we),
        .ex_rd(ex_rd),
        .ex_rd_we(ex_rd_we),
        .flush(flush),
        .wb_valid(wb_valid),
        .wb_ready(wb_ready),
        .wb_result(wb_result),
        .wb_rd(wb_rd),
        .wb_rd_we(wb_rd_we),
        .cf_flag(cf_flag),
        .fwd_query_rd(fwd_query_rd),
        .fwd_hit(fwd_hit),
        .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic put(input logic v, input logic [31:0] r,
                       input logic [4:0] d, input logic we,
                       input logic c, input logic cwe);
        ex_valid  = v;
        ex_result = r;
        ex_rd     = d;
        ex_rd_we  = we;
        ex_cf     = c;
        ex_cf_we  = cwe;
    endtask

    // One clock: scoreboard push/pop before the edge, carry model after.
    task automatic cycle();
        sb_t e;
        #1;
        if (rst) begin
            q.delete();
            exp_cf = 1'b0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (wb_valid && wb_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got result=%h, required no entry", wb_result);
                end else begin
                    e = q.pop_front();
                    if (wb_result !== e.result || wb_rd !== e.rd || wb_rd_we !== e.rd_we) begin
                        errors++;
                        $display("FAIL sb_pop: got %h/%0d/%b, required %h/%0d/%b",
                                 wb_result, wb_rd, wb_rd_we, e.result, e.rd, e.rd_we);
                    end
                    if (e.cf_we) exp_cf = e.cf;
                end
            end
            if (ex_valid && ex_ready) begin
                e.result = ex_result;
                e.rd     = ex_rd;
                e.rd_we  = ex_rd_we && (ex_rd != 5'd0);
                e.cf     = ex_cf;
                e.cf_we  = ex_cf_we;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (cf_flag !== exp_cf) begin
            errors++;
            $display("FAIL cf_model: got %b, required %b", cf_flag, exp_cf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks += 7;
        if (ex_ready !== 1'b1) begin errors++; $display("FAIL rst_ex_ready: got %b, required 1", ex_ready); end
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b, required 0", wb_valid); end
        if (wb_rd_we !== 1'b0) begin errors++; $display("FAIL rst_wb_rd_we: got %b, required 0", wb_rd_we); end
        if (fwd_hit !== 1'b0) begin errors++; $display("FAIL rst_fwd_hit: got %b, required 0", fwd_hit); end
        if (wb_result !== 32'h0) begin errors++; $display("FAIL rst_wb_result: got %h, required 0", wb_result); end
        if (wb_rd !== 5'd0) begin errors++; $display("FAIL rst_wb_rd: got %0d, required 0", wb_rd); end
        if (fwd_data !== 32'h0) begin errors++; $display("FAIL rst_fwd_data: got %h, required 0", fwd_data); end
    endtask

    task automatic test_single();
        wb_ready = 1'b1;
        put(1'b1, 32'h0000_0010, 5'd3, 1'b1, 1'b1, 1'b1);
        cycle();
        put(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks += 4;
        if (wb_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, required 1", wb_valid); end
        if (wb_result !== 32'h10) begin errors++; $display("FAIL single_result: got %h, required 10", wb_result); end
        if (wb_rd !== 5'd3) begin errors++; $display("FAIL single_rd: got %0d, required 3", wb_rd); end
        if (cf_flag !== 1'b0) begin errors++; $display("FAIL single_cf_early: got %b, required 0", cf_flag); end
        cycle();
        checks += 2;
        if (cf_flag !== 1'b1) begin errors++; $display("FAIL single_cf: got %b, required 1", cf_flag); end
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b, required 0", wb_valid); end
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        put(1'b1, 32'hA, 5'd1, 1'b1, 1'b0, 1'b0);
        cycle();
        checks += 2;
        if (ex_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b, required 1", ex_ready); end
        if (wb_result !== 32'hA) begin errors++; $display("FAIL bp_head_a: got %h, required a", wb_result); end
        put(1'b1, 32'hB, 5'd2, 1'b1, 1'b0, 1'b0);
        cycle();
        put(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (ex_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b, required 0", ex_ready); end
        if (wb_result !== 32'hA) begin errors++; $display("FAIL bp_hold_a: got %h, required a", wb_result); end
        wb_ready = 1'b1;
        cycle();
        checks += 2;
        if (wb_result !== 32'hB) begin errors++; $display("FAIL bp_head_b: got %h, required b", wb_result); end
        if (ex_ready !== 1'b1) begin errors++; $display("FAIL bp_ready2: got %b, required 1", ex_ready); end
        cycle();
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b, required 0", wb_valid); end
    endtask

    task automatic test_forward();
        wb_ready = 1'b0;
        put(1'b1, 32'h1111, 5'd5, 1'b1, 1'b0, 1'b0);
        cycle();
        put(1'b1, 32'h2222, 5'd5, 1'b1, 1'b0, 1'b0);
        cycle();
        put(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        fwd_query_rd = 5'd5;
        #1;
        checks += 2;
        if (fwd_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit5: got %b, required 1", fwd_hit); end
        if (fwd_data !== 32'h2222) begin errors++; $display("FAIL fwd_newest: got %h, required 2222", fwd_data); end
        fwd_query_rd = 5'd6;
        #1;
        checks += 2;
        if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss6: got %b, required 0", fwd_hit); end
        if (fwd_data !== 32'h0) begin errors++; $display("FAIL fwd_data6: got %h, required 0", fwd_data); end
        wb_ready = 1'b1;
        cycle();
        fwd_query_rd = 5'd5;
        #1;
        checks++;
        if (fwd_data !== 32'h2222) begin errors++; $display("FAIL fwd_head: got %h, required 2222", fwd_data); end
        cycle();
        wb_ready = 1'b0;
        put(1'b1, 32'h33, 5'd0, 1'b1, 1'b0, 1'b0);
        cycle();
        put(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        fwd_query_rd = 5'd0;
        #1;
        checks += 3;
        if (wb_valid !== 1'b1) begin errors++; $display("FAIL x0_valid: got %b, required 1", wb_valid); end
        if (wb_rd_we !== 1'b0) begin errors++; $display("FAIL x0_rd_we: got %b, required 0", wb_rd_we); end
        if (fwd_hit !== 1'b0) begin errors++; $display("FAIL x0_fwd: got %b, required 0", fwd_hit); end
        wb_ready = 1'b1;
        cycle();
    endtask

    task automatic test_carry();
        wb_ready = 1'b1;
        put(1'b1, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1);
        cycle();
        put(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle();
        checks++;
        if (cf_flag !== 1'b0) begin errors++; $display("FAIL carry_pre: got %b, required 0", cf_flag); end
        wb_ready = 1'b0;
        put(1'b1, 32'hC1, 5'd10, 1'b1, 1'b1, 1'b1);
        cycle();
        put(1'b1, 32'hC2, 5'd11, 1'b1, 1'b0, 1'b0);
        cycle();
        put(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        wb_ready = 1'b1;
        cycle();
        checks++;
        if (cf_flag !== 1'b1) begin errors++; $display("FAIL carry_set: got %b, required 1", cf_flag); end
        put(1'b1, 32'hC3, 5'd12, 1'b1, 1'b0, 1'b1);
        cycle();
        put(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cf_flag !== 1'b1) begin errors++; $display("FAIL carry_hold: got %b, required 1", cf_flag); end
        cycle();
        checks++;
        if (cf_flag !== 1'b0) begin errors++; $display("FAIL carry_clear: got %b, required 0", cf_flag); end
    endtask

    task automatic test_flush();
        wb_ready = 1'b0;
        put(1'b1, 32'hF1, 5'd13, 1'b1, 1'b1, 1'b1);
        cycle();
        put(1'b1, 32'hF2, 5'd14, 1'b1, 1'b1, 1'b1);
        cycle();
        put(1'b1, 32'hF3, 5'd15, 1'b1, 1'b1, 1'b1);
        wb_ready = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        put(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks += 3;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, required 0", wb_valid); end
        if (ex_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b, required 1", ex_ready); end
        if (cf_flag !== 1'b0) begin errors++; $display("FAIL flush_cf: got %b, required 0", cf_flag); end
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost: got %h, required none", wb_result); end
        end
    endtask

    task automatic test_reset_full();
        wb_ready = 1'b1;
        put(1'b1, 32'h5, 5'd7, 1'b1, 1'b1, 1'b1);
        cycle();
        put(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle();
        wb_ready = 1'b0;
        put(1'b1, 32'h6, 5'd7, 1'b1, 1'b0, 1'b1);
        cycle();
        put(1'b1, 32'h7, 5'd7, 1'b1, 1'b0, 1'b1);
        cycle();
        put(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        fwd_query_rd = 5'd7;
        wb_ready = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks += 7;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL rf_valid: got %b, required 0", wb_valid); end
        if (ex_ready !== 1'b1) begin errors++; $display("FAIL rf_ready: got %b, required 1", ex_ready); end
        if (cf_flag !== 1'b0) begin errors++; $display("FAIL rf_cf: got %b, required 0", cf_flag); end
        if (fwd_hit !== 1'b0) begin errors++; $display("FAIL rf_fwd: got %b, required 0", fwd_hit); end
        if (wb_result !== 32'h0) begin errors++; $display("FAIL rf_result: got %h, required 0", wb_result); end
        if (wb_rd_we !== 1'b0) begin errors++; $display("FAIL rf_rd_we: got %b, required 0", wb_rd_we); end
        if (fwd_data !== 32'h0) begin errors++; $display("FAIL rf_fwd_data: got %h, required 0", fwd_data); end
    endtask

    task automatic test_back_to_back();
        wb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            put(1'b1, 32'h100 + i, 5'(i + 1), 1'b1, i[0], 1'b1);
            cycle();
            checks++;
            if (ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b, required 1", ex_ready); end
        end
        for (int i = 0; i < 60; i++) begin
            put(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
            wb_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        put(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        checks += 2;
        if (q.size() != 0) begin errors++; $display("FAIL b2b_left: got %0d, required 0", q.size()); end
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b, required 0", wb_valid); end
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        wb_ready     = 1'b0;
        fwd_query_rd = 5'd0;
        exp_cf       = 1'b0;
        put(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_single();
        test_backpressure();
        test_forward();
        test_carry();
        test_flush();
        test_reset_full();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
